// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, per-CSR
// write masks, mstatus field positions, operation encoding, privilege levels
// and interrupt cause codes.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [11:0] CSR_SATP     = 12'h180;

    // mstatus field bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Interrupt cause codes, which are also their mip/mie bit positions
    localparam int IRQ_SOFT  = 3;
    localparam int IRQ_TIMER = 7;
    localparam int IRQ_EXT   = 11;

    // Software write masks, stated at 64 bits and truncated to XLEN by users.
    // mstatus: only MIE, MPIE and MPP exist in this M/U-only hart.
    localparam logic [63:0] WMASK_MSTATUS = 64'h0000_0000_0000_1888;
    // mtvec: bit 1 of MODE is reserved, bit 0 selects vectored mode.
    localparam logic [63:0] WMASK_MTVEC   = 64'hFFFF_FFFF_FFFF_FFFD;
    // mip: the only implemented bits are hardware-owned.
    localparam logic [63:0] WMASK_MIP     = 64'h0000_0000_0000_0000;
    // mie: enables exist only for the three implemented interrupts.
    localparam logic [63:0] WMASK_MIE     = 64'h0000_0000_0000_0888;
    // mepc: instructions are at least 2-byte aligned.
    localparam logic [63:0] WMASK_MEPC    = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] WMASK_ALL     = 64'hFFFF_FFFF_FFFF_FFFF;

    // CSR instruction operation
    typedef enum logic [1:0] {
        CSR_OP_RW   = 2'd0,
        CSR_OP_RS   = 2'd1,
        CSR_OP_RC   = 2'd2,
        CSR_OP_RSVD = 2'd3
    } csr_op_t;

    // Privilege levels
    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_M = 2'd3;

    // Only M and U exist, so any other MPP encoding collapses to U.
    function automatic logic [1:0] legal_priv(input logic [1:0] p);
        return (p == PRIV_M) ? PRIV_M : PRIV_U;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter used for mcycle and minstret. A load takes priority
// over the increment so a software write is seen exactly on the next cycle.
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    // Counter state: reset, then load, then wrapping increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read-modify-write, trap entry and mret
// sequencing, privilege tracking, mcycle, interrupt pending evaluation and
// illegal access detection. Optional minstret counter and retire input are
// enabled by defining CSR_MINSTRET_EN.
module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN              = 64,
    parameter int unsigned HART_ID           = 0,
    parameter int          VECTORED_EN_RESET = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            irq_timer,
    input  logic            irq_soft,
    input  logic            irq_ext,
`ifdef CSR_MINSTRET_EN
    input  logic            retire,
`endif
    output logic            irq_pending,
    output logic [1:0]      priv_mode,
    output logic [XLEN-1:0] satp_out
);

    localparam logic [XLEN-1:0] MTVEC_RESET = XLEN'(VECTORED_EN_RESET != 0);
    localparam logic [XLEN-1:0] HART_VALUE  = XLEN'(HART_ID);

    // Architectural state
    logic [XLEN-1:0] mstatus_reg, mstatus_next;
    logic [XLEN-1:0] mtvec_reg, mtvec_next;
    logic [XLEN-1:0] mip_reg;
    logic [XLEN-1:0] mie_reg, mie_next;
    logic [XLEN-1:0] mscratch_reg, mscratch_next;
    logic [XLEN-1:0] mcause_reg, mcause_next;
    logic [XLEN-1:0] mtval_reg, mtval_next;
    logic [XLEN-1:0] mepc_reg, mepc_next;
    logic [XLEN-1:0] satp_reg, satp_next;
    logic [1:0]      priv_reg, priv_next;
    logic [XLEN-1:0] mcycle_val;
`ifdef CSR_MINSTRET_EN
    logic [XLEN-1:0] minstret_val;
`endif

    // Decode and datapath
    csr_op_t         op;
    logic            addr_known;
    logic            addr_ro;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] wmask;
    logic [XLEN-1:0] new_raw;
    logic [XLEN-1:0] wr_val;
    logic            write_attempt;
    logic            csr_we;
    logic [XLEN-1:0] mip_hw;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] vec_offset;
    logic [XLEN-1:0] trap_target;

    assign op = csr_op_t'(csr_op);

    // Hardware-owned mip bits: each interrupt line lands on its cause bit
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_mip_hw
            if (gi == IRQ_SOFT) begin : g_soft
                assign mip_hw[gi] = irq_soft;
            end else if (gi == IRQ_TIMER) begin : g_timer
                assign mip_hw[gi] = irq_timer;
            end else if (gi == IRQ_EXT) begin : g_ext
                assign mip_hw[gi] = irq_ext;
            end else begin : g_zero
                assign mip_hw[gi] = 1'b0;
            end
        end
    endgenerate

    // Address decode: current value, write mask and access class per CSR
    always_comb begin
        addr_known = 1'b1;
        addr_ro    = 1'b0;
        old_val    = '0;
        wmask      = '0;
        case (csr_addr)
            CSR_MSTATUS:  begin old_val = mstatus_reg;  wmask = XLEN'(WMASK_MSTATUS); end
            CSR_MTVEC:    begin old_val = mtvec_reg;    wmask = XLEN'(WMASK_MTVEC);   end
            CSR_MIP:      begin old_val = mip_reg;      wmask = XLEN'(WMASK_MIP);     end
            CSR_MIE:      begin old_val = mie_reg;      wmask = XLEN'(WMASK_MIE);     end
            CSR_MSCRATCH: begin old_val = mscratch_reg; wmask = XLEN'(WMASK_ALL);     end
            CSR_MCAUSE:   begin old_val = mcause_reg;   wmask = XLEN'(WMASK_ALL);     end
            CSR_MTVAL:    begin old_val = mtval_reg;    wmask = XLEN'(WMASK_ALL);     end
            CSR_MEPC:     begin old_val = mepc_reg;     wmask = XLEN'(WMASK_MEPC);    end
            CSR_MCYCLE:   begin old_val = mcycle_val;   wmask = XLEN'(WMASK_ALL);     end
            CSR_SATP:     begin old_val = satp_reg;     wmask = XLEN'(WMASK_ALL);     end
            CSR_MHARTID:  begin old_val = HART_VALUE;   addr_ro = 1'b1;               end
`ifdef CSR_MINSTRET_EN
            CSR_MINSTRET: begin old_val = minstret_val; wmask = XLEN'(WMASK_ALL);     end
`endif
            default:      addr_known = 1'b0;
        endcase
    end

    // Read-modify-write value; RS/RC with zero operand is a pure read
    always_comb begin
        case (op)
            CSR_OP_RW: new_raw = csr_wdata;
            CSR_OP_RS: new_raw = old_val | csr_wdata;
            CSR_OP_RC: new_raw = old_val & ~csr_wdata;
            default:   new_raw = old_val;
        endcase
    end

    assign wr_val        = new_raw & wmask;
    assign write_attempt = (op == CSR_OP_RW) || (csr_wdata != '0);
    assign csr_illegal   = csr_valid &&
                           (!addr_known || (op == CSR_OP_RSVD) || (addr_ro && write_attempt));
    // Traps and mret outrank the CSR instruction, which is then dropped whole
    assign csr_we        = csr_valid && !csr_illegal && write_attempt &&
                           !trap_valid && !mret_valid;

    // Next-state selection with trap > mret > CSR write priority
    always_comb begin
        mstatus_next  = mstatus_reg;
        mtvec_next    = mtvec_reg;
        mie_next      = mie_reg;
        mscratch_next = mscratch_reg;
        mcause_next   = mcause_reg;
        mtval_next    = mtval_reg;
        mepc_next     = mepc_reg;
        satp_next     = satp_reg;
        priv_next     = priv_reg;
        if (trap_valid) begin
            mepc_next    = trap_pc & XLEN'(WMASK_MEPC);
            mcause_next  = trap_cause;
            mtval_next   = trap_tval;
            mstatus_next[MSTATUS_MPIE] = mstatus_reg[MSTATUS_MIE];
            mstatus_next[MSTATUS_MIE]  = 1'b0;
            mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_reg;
            priv_next    = PRIV_M;
        end else if (mret_valid) begin
            mstatus_next[MSTATUS_MIE]  = mstatus_reg[MSTATUS_MPIE];
            mstatus_next[MSTATUS_MPIE] = 1'b1;
            mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
            priv_next    = legal_priv(mstatus_reg[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_next = wr_val;
                    mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] =
                        legal_priv(wr_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
                end
                CSR_MTVEC:    mtvec_next    = wr_val;
                CSR_MIE:      mie_next      = wr_val;
                CSR_MSCRATCH: mscratch_next = wr_val;
                CSR_MCAUSE:   mcause_next   = wr_val;
                CSR_MTVAL:    mtval_next    = wr_val;
                CSR_MEPC:     mepc_next     = wr_val;
                CSR_SATP:     satp_next     = wr_val;
                default:      ;
            endcase
        end
    end

    // State registers; mip samples the interrupt lines every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_reg  <= '0;
            mtvec_reg    <= MTVEC_RESET;
            mip_reg      <= '0;
            mie_reg      <= '0;
            mscratch_reg <= '0;
            mcause_reg   <= '0;
            mtval_reg    <= '0;
            mepc_reg     <= '0;
            satp_reg     <= '0;
            priv_reg     <= PRIV_M;
        end else begin
            mstatus_reg  <= mstatus_next;
            mtvec_reg    <= mtvec_next;
            mip_reg      <= mip_hw;
            mie_reg      <= mie_next;
            mscratch_reg <= mscratch_next;
            mcause_reg   <= mcause_next;
            mtval_reg    <= mtval_next;
            mepc_reg     <= mepc_next;
            satp_reg     <= satp_next;
            priv_reg     <= priv_next;
        end
    end

    csr_counter #(.WIDTH(XLEN)) u_mcycle (
        .clk        (clk),
        .rst        (rst),
        .inc        (1'b1),
        .load       (csr_we && (csr_addr == CSR_MCYCLE)),
        .load_value (wr_val),
        .count      (mcycle_val)
    );

`ifdef CSR_MINSTRET_EN
    // A retire in a trap cycle still counts; only a software write stops it
    csr_counter #(.WIDTH(XLEN)) u_minstret (
        .clk        (clk),
        .rst        (rst),
        .inc        (retire),
        .load       (csr_we && (csr_addr == CSR_MINSTRET)),
        .load_value (wr_val),
        .count      (minstret_val)
    );
`endif

    // Trap target: interrupts in vectored mode jump to base + 4*cause
    assign mtvec_base  = {mtvec_reg[XLEN-1:2], 2'b00};
    assign vec_offset  = {trap_cause[XLEN-3:0], 2'b00};
    assign trap_target = (mtvec_reg[0] && trap_cause[XLEN-1]) ? (mtvec_base + vec_offset)
                                                               : mtvec_base;

    assign redirect_valid = trap_valid || mret_valid;
    assign redirect_pc    = trap_valid ? trap_target :
                            mret_valid ? mepc_reg    : '0;

    // Below M mode interrupts are globally enabled regardless of MIE
    assign irq_pending = (|(mip_reg & mie_reg)) &&
                         (mstatus_reg[MSTATUS_MIE] || (priv_reg != PRIV_M));

    assign csr_rdata = old_val;
    assign priv_mode = priv_reg;
    assign satp_out  = satp_reg;

endmodule
